// File: rtl/matvec_pkg.sv
// Shared types and width helpers for the matrix-vector multiplier.
package matvec_pkg;

    typedef enum logic [1:0] {
        S_LOAD_W,
        S_LOAD_X,
        S_MAC,
        S_OUT
    } state_t;

    // Accumulator width: full-precision product plus enough headroom to sum
    // n of them without overflow.
    function automatic int acc_width(input int in_w, input int n);
        return 2 * in_w + $clog2(n);
    endfunction

endpackage

// File: rtl/matvec_mac.sv
// Multiply-accumulate datapath with registered result.
// Build option MATVEC_SAT_EN: when defined the result is clamped to the signed
// OUT_W range; otherwise the low OUT_W bits of the accumulator are taken.
module matvec_mac
    import matvec_pkg::*;
#(
    parameter int IN_W  = 14,
    parameter int OUT_W = 28,
    parameter int ACC_W = 30
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    en,
    input  logic                    capture,
    input  logic signed [IN_W-1:0]  w_elem,
    input  logic signed [IN_W-1:0]  x_elem,
    output logic signed [OUT_W-1:0] result
);

    logic signed [2*IN_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [OUT_W-1:0]  result_next;

    assign prod     = w_elem * x_elem;
    assign acc_next = acc + ACC_W'(prod);

`ifdef MATVEC_SAT_EN
    localparam int EXT_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'({1'b0, {(OUT_W-1){1'b1}}});
    localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [EXT_W-1:0] acc_ext;

    assign acc_ext = EXT_W'(acc_next);

    // Clamp the finished sum into the representable output range.
    always_comb begin
        result_next = OUT_W'(acc_ext);
        if (acc_ext > SAT_MAX) begin
            result_next = OUT_W'(SAT_MAX);
        end else if (acc_ext < SAT_MIN) begin
            result_next = OUT_W'(SAT_MIN);
        end
    end
`else
    assign result_next = OUT_W'(acc_next);
`endif

    // Accumulator: cleared at the start of each row, one product added per MAC cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_next;
        end
    end

    // Result register: captures the row sum on the last MAC step and holds it
    // while the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            result <= '0;
        end else if (capture) begin
            result <= result_next;
        end
    end

endmodule

// File: rtl/matvec_param.sv
// N x N signed matrix times N-vector, streamed in and out over valid/ready.
// The matrix is kept between transactions so vector-only requests can reuse it.
// Build option MATVEC_SAT_EN selects saturating output (see matvec_mac).
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_LOAD_W | idle / receiving matrix words row-major (row, col)
//   S_LOAD_X | receiving vector words x[col]
//   S_MAC    | one multiply-accumulate per cycle for the current row
//   S_OUT    | row result presented, waiting for output_ready
module matvec_param
    import matvec_pkg::*;
#(
    parameter int N     = 3,
    parameter int IN_W  = 14,
    parameter int OUT_W = 28
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    input_valid,
    output logic                    input_ready,
    input  logic signed [IN_W-1:0]  input_data,
    input  logic                    input_load_w,
    output logic                    output_valid,
    input  logic                    output_ready,
    output logic signed [OUT_W-1:0] output_data
);

    localparam int ACC_W = acc_width(IN_W, N);
    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    state_t state;
    state_t state_next;

    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
    logic             w_loaded;

    logic signed [IN_W-1:0] w_mem [N][N];
    logic signed [IN_W-1:0] x_mem [N];

    logic in_fire;
    logic out_fire;
    logic first_word;
    logic reuse_w;
    logic mac_en;
    logic mac_clear;
    logic mac_capture;

    assign in_fire    = input_valid && input_ready;
    assign out_fire   = output_valid && output_ready;
    // Row/col are both zero in S_LOAD_W only when nothing of this transaction
    // has been taken yet, so that is where the load_w sideband is honoured.
    assign first_word = (state == S_LOAD_W) && (row == '0) && (col == '0);
    assign reuse_w    = first_word && !input_load_w && w_loaded;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_LOAD_W;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and handshake / datapath strobes.
    always_comb begin
        state_next   = state;
        input_ready  = 1'b0;
        output_valid = 1'b0;
        mac_en       = 1'b0;
        mac_clear    = 1'b0;
        mac_capture  = 1'b0;
        case (state)
            S_LOAD_W: begin
                input_ready = 1'b1;
                if (in_fire) begin
                    if (reuse_w) begin
                        state_next = S_LOAD_X;
                    end else if ((row == LAST) && (col == LAST)) begin
                        state_next = S_LOAD_X;
                    end
                end
            end
            S_LOAD_X: begin
                input_ready = 1'b1;
                if (in_fire && (col == LAST)) begin
                    state_next = S_MAC;
                    mac_clear  = 1'b1;
                end
            end
            S_MAC: begin
                mac_en = 1'b1;
                if (col == LAST) begin
                    mac_capture = 1'b1;
                    state_next  = S_OUT;
                end
            end
            S_OUT: begin
                output_valid = 1'b1;
                if (output_ready) begin
                    if (row == LAST) begin
                        state_next = S_LOAD_W;
                    end else begin
                        state_next = S_MAC;
                        mac_clear  = 1'b1;
                    end
                end
            end
            default: state_next = S_LOAD_W;
        endcase
    end

    // Row/col indices drive both the load addressing and the MAC sequencing.
    always_ff @(posedge clk) begin
        if (reset) begin
            row      <= '0;
            col      <= '0;
            w_loaded <= 1'b0;
        end else begin
            case (state)
                S_LOAD_W: begin
                    if (in_fire) begin
                        if (reuse_w) begin
                            col <= IDX_W'(1);
                        end else begin
                            // A fresh matrix is being written; the old one is gone.
                            if (first_word) begin
                                w_loaded <= 1'b0;
                            end
                            if (col == LAST) begin
                                col <= '0;
                                if (row == LAST) begin
                                    row      <= '0;
                                    w_loaded <= 1'b1;
                                end else begin
                                    row <= row + 1'b1;
                                end
                            end else begin
                                col <= col + 1'b1;
                            end
                        end
                    end
                end
                S_LOAD_X: begin
                    if (in_fire) begin
                        col <= (col == LAST) ? '0 : col + 1'b1;
                    end
                end
                S_MAC: begin
                    col <= (col == LAST) ? '0 : col + 1'b1;
                end
                S_OUT: begin
                    if (out_fire) begin
                        row <= (row == LAST) ? '0 : row + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand storage: plain flop arrays addressed by the load indices.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            if ((state == S_LOAD_X) || reuse_w) begin
                x_mem[col] <= input_data;
            end else begin
                w_mem[row][col] <= input_data;
            end
        end
    end

    matvec_mac #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk     (clk),
        .reset   (reset),
        .clear   (mac_clear),
        .en      (mac_en),
        .capture (mac_capture),
        .w_elem  (w_mem[row][col]),
        .x_elem  (x_mem[col]),
        .result  (output_data)
    );

endmodule
